assert_collector: RTL and testbench

// - Consumer end of the assertion-checker interface: samples per-cycle `valid` flags from N assertion checkers, accumulates pass/fail results.
// - Sits beside the DUT in the top-level proof/sim harness, one instance per assertion group.
// - Reports sticky fail flags, a saturating failure count and the ID and cycle of the first failure.
// - Start/stop controlled; settle window skips checker warm-up cycles after start.

---
 rtl/assert_collector_pkg.sv | 28 ++
 rtl/sat_counter.sv | 20 ++
 rtl/assert_collector.sv | 113 +++++++++++
 tb/tb_assert_collector.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/assert_collector_pkg.sv
// rtl/assert_collector_pkg.sv - shared types and helpers for the assertion collector
package assert_collector_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam int STATE_W    = 2;
    localparam int MAX_ASSERT = 64;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Lowest set index; callers zero-extend their vector to MAX_ASSERT bits.
    function automatic int lowest_set(input logic [MAX_ASSERT-1:0] v);
        int idx;
        idx = 0;
        for (int i = MAX_ASSERT - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/assert_collector.sv
// rtl/assert_collector.sv - samples assertion checker flags and accumulates run statistics
module assert_collector
    import assert_collector_pkg::*;
#(
    parameter int N_ASSERT = 4,
    parameter int CNT_W    = 16,
    parameter int SETTLE   = 2,
    localparam int ID_W    = id_width(N_ASSERT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [N_ASSERT-1:0] valid,
    input  logic [N_ASSERT-1:0] mask,
    output logic [STATE_W-1:0]  state,
    output logic                done,
    output logic                fail,
    output logic [N_ASSERT-1:0] fail_vec,
    output logic [CNT_W-1:0]    fail_count,
    output logic [CNT_W-1:0]    cyc_count,
    output logic [ID_W-1:0]     first_fail_id,
    output logic [CNT_W-1:0]    first_fail_cyc
);

    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_e RUN_ENTRY = (SETTLE > 0) ? S_SETTLE : S_CHECK;

    state_e              state_q, state_d;
    logic                clr_stats;
    logic                check_en;
    logic [SW-1:0]       settle_q;
    logic [N_ASSERT-1:0] f;
    logic                any_f;

    // Masked bits drop out here, so X on their valid never propagates.
    assign f     = ~valid & ~mask;
    assign any_f = |f;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        clr_stats = 1'b0;
        check_en  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clr_stats = 1'b1;
                    state_d   = RUN_ENTRY;
                end
            end
            S_SETTLE: begin
                if (stop)                         state_d = S_DONE;
                else if (settle_q == SETTLE_LAST) state_d = S_CHECK;
            end
            S_CHECK: begin
                check_en = 1'b1;
                if (stop) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    sat_counter #(.W(SW)) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (state_q == S_SETTLE),
        .q   (settle_q)
    );

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (check_en),
        .q   (cyc_count)
    );

    sat_counter #(.W(CNT_W)) u_fail_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (check_en && any_f),
        .q   (fail_count)
    );

    // first_fail_cyc captures cyc_count before this cycle's increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            fail           <= 1'b0;
            fail_vec       <= '0;
            first_fail_id  <= '0;
            first_fail_cyc <= '0;
        end else if (check_en) begin
            fail_vec <= fail_vec | f;
            fail     <= fail | any_f;
            if (any_f && !fail) begin
                first_fail_id  <= ID_W'(lowest_set(MAX_ASSERT'(f)));
                first_fail_cyc <= cyc_count;
            end
        end
    end

    assign state = state_q;
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_assert_collector.sv
// tb/tb_assert_collector.sv - directed self-checking bench for assert_collector
module tb_assert_collector;

    logic       clk = 1'b0;
    logic       rst, start, stop;
    logic [3:0] valid, mask;
    logic [1:0] state;
    logic       done, fail;
    logic [3:0] fail_vec;
    logic [15:0] fail_count, cyc_count, first_fail_cyc;
    logic [1:0] first_fail_id;

    logic       s_rst, s_start, s_stop;
    logic [3:0] s_valid, s_mask;
    logic [1:0] s_state;
    logic       s_done, s_fail;
    logic [3:0] s_fail_vec;
    logic [2:0] s_fail_count, s_cyc_count, s_first_fail_cyc;
    logic [1:0] s_first_fail_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assert_collector #(.N_ASSERT(4), .CNT_W(16), .SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .mask(mask),
        .state(state), .done(done), .fail(fail), .fail_vec(fail_vec),
        .fail_count(fail_count), .cyc_count(cyc_count),
        .first_fail_id(first_fail_id), .first_fail_cyc(first_fail_cyc)
    );

    assert_collector #(.N_ASSERT(4), .CNT_W(3), .SETTLE(0)) dut_s (
        .clk(clk), .rst(s_rst), .start(s_start), .stop(s_stop), .valid(s_valid), .mask(s_mask),
        .state(s_state), .done(s_done), .fail(s_fail), .fail_vec(s_fail_vec),
        .fail_count(s_fail_count), .cyc_count(s_cyc_count),
        .first_fail_id(s_first_fail_id), .first_fail_cyc(s_first_fail_cyc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag, input logic [1:0] st, input logic fl,
                               input logic [3:0] fv, input logic [15:0] fc, input logic [15:0] cc,
                               input logic [1:0] fid, input logic [15:0] fcyc);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".done"}, 32'(done), 32'(st == 2'd3));
        check({tag, ".fail"}, 32'(fail), 32'(fl));
        check({tag, ".fail_vec"}, 32'(fail_vec), 32'(fv));
        check({tag, ".fail_count"}, 32'(fail_count), 32'(fc));
        check({tag, ".cyc_count"}, 32'(cyc_count), 32'(cc));
        check({tag, ".first_fail_id"}, 32'(first_fail_id), 32'(fid));
        check({tag, ".first_fail_cyc"}, 32'(first_fail_cyc), 32'(fcyc));
    endtask

    // From IDLE/DONE: start edge plus two settle edges lands in CHECK.
    task automatic run_to_check(input string tag);
        start = 1'b1;
        tick();
        check({tag, ".settle_entry"}, 32'(state), 32'd1);
        check({tag, ".cleared"}, 32'({fail, fail_vec, cyc_count}), 32'd0);
        start = 1'b0;
        tick();
        tick();
        check({tag, ".check_entry"}, 32'(state), 32'd2);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; valid = 4'hF; mask = 4'h0;
        s_rst = 1'b1; s_start = 1'b0; s_stop = 1'b0; s_valid = 4'hF; s_mask = 4'h0;
        tick();
        tick();
        rst = 1'b0; s_rst = 1'b0;
        check_stats("reset", 2'd0, 1'b0, 4'h0, 16'd0, 16'd0, 2'd0, 16'd0);

        // clean run; valid[0] low during settle must be ignored
        valid = 4'b1110;
        run_to_check("clean");
        valid = 4'hF;
        for (int i = 0; i < 10; i++) begin
            stop = (i == 9);
            tick();
        end
        stop = 1'b0;
        check_stats("clean", 2'd3, 1'b0, 4'h0, 16'd0, 16'd10, 2'd0, 16'd0);
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("clean.frozen_cyc", 32'(cyc_count), 32'd10);

        // single failure on checker 2 in the 4th CHECK cycle
        run_to_check("single");
        for (int i = 0; i < 6; i++) begin
            valid = (i == 3) ? 4'b1011 : 4'hF;
            stop  = (i == 5);
            tick();
            if (i == 2) check("single.pre_fail", 32'(fail), 32'd0);
            if (i == 3) check("single.fail_now", 32'(fail), 32'd1);
        end
        stop = 1'b0; valid = 4'hF;
        check_stats("single", 2'd3, 1'b1, 4'b0100, 16'd1, 16'd6, 2'd2, 16'd3);

        // masked failure, multi-bit failure, late masking, X on masked bit
        run_to_check("multi");
        valid = 4'b1110; mask = 4'b0001;
        tick();
        check("multi.masked_fail", 32'(fail), 32'd0);
        check("multi.masked_count", 32'(fail_count), 32'd0);
        valid = 4'b0101; mask = 4'b0000;
        tick();
        valid = 4'hF; mask = 4'b1010;
        tick();
        valid = 4'b111x; mask = 4'b0001; stop = 1'b1;
        tick();
        valid = 4'hF; mask = 4'h0; stop = 1'b0;
        check_stats("multi", 2'd3, 1'b1, 4'b1010, 16'd1, 16'd4, 2'd1, 16'd1);

        // start+stop together in CHECK: stop wins, stats kept
        run_to_check("startstop");
        valid = 4'b0111;
        tick();
        valid = 4'hF; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_stats("startstop", 2'd3, 1'b1, 4'b1000, 16'd1, 16'd2, 2'd3, 16'd0);

        // stop during SETTLE: DONE with no checks
        start = 1'b1;
        tick();
        start = 1'b0; stop = 1'b1; valid = 4'h0;
        tick();
        stop = 1'b0; valid = 4'hF;
        check_stats("settle_stop", 2'd3, 1'b0, 4'h0, 16'd0, 16'd0, 2'd0, 16'd0);

        // reset mid-CHECK
        run_to_check("midrst");
        valid = 4'h0;
        tick();
        check("midrst.fail", 32'(fail), 32'd1);
        valid = 4'hF; rst = 1'b1;
        tick();
        rst = 1'b0;
        check_stats("midrst", 2'd0, 1'b0, 4'h0, 16'd0, 16'd0, 2'd0, 16'd0);

        // saturation with CNT_W=3, SETTLE=0
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("sat.check_entry", 32'(s_state), 32'd2);
        s_valid = 4'h0;
        for (int i = 0; i < 10; i++) begin
            s_stop = (i == 9);
            tick();
        end
        s_stop = 1'b0; s_valid = 4'hF;
        check("sat.state", 32'(s_state), 32'd3);
        check("sat.done", 32'(s_done), 32'd1);
        check("sat.fail_count", 32'(s_fail_count), 32'd7);
        check("sat.cyc_count", 32'(s_cyc_count), 32'd7);
        check("sat.fail_vec", 32'(s_fail_vec), 32'hF);
        check("sat.first_fail_id", 32'(s_first_fail_id), 32'd0);
        check("sat.first_fail_cyc", 32'(s_first_fail_cyc), 32'd0);
        check("sat.fail", 32'(s_fail), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
